// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage CPU: tracks EX/MEM destinations,
// selects ID operand forwarding, raises load-use/branch stalls and redirects the PC.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rn,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic             rsrtequ,
    input  logic             clr_cnt,
    output logic             wpcir,
    output logic             ex_bubble,
    output logic             flush_ifid,
    output logic [1:0]       pcsource,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [5:0] {
        OP_RTYPE0 = 6'b000000,
        OP_RTYPE1 = 6'b000001,
        OP_SHIFT  = 6'b000010,
        OP_ADDI   = 6'b000101,
        OP_ANDI   = 6'b001001,
        OP_ORI    = 6'b001010,
        OP_XORI   = 6'b001100,
        OP_LW     = 6'b001101,
        OP_SW     = 6'b001110,
        OP_BEQ    = 6'b001111,
        OP_BNE    = 6'b010000,
        OP_J      = 6'b010010
    } opcode_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_LOAD = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pcsrc_e;

    logic             ex_v_q, ex_v_d;
    logic             ex_wreg_q, ex_wreg_d;
    logic             ex_m2reg_q, ex_m2reg_d;
    logic [4:0]       ex_rn_q, ex_rn_d;
    logic             mem_v_q, mem_v_d;
    logic             mem_wreg_q, mem_wreg_d;
    logic             mem_m2reg_q, mem_m2reg_d;
    logic [4:0]       mem_rn_q, mem_rn_d;
    logic             id_kill_q, id_kill_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic legal, uses_rs, uses_rt, is_beq, is_bne, is_j;
    logic id_valid, stall, redirect;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    always_comb begin
        legal   = 1'b1;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beq  = 1'b0;
        is_bne  = 1'b0;
        is_j    = 1'b0;
        case (id_op)
            OP_RTYPE0, OP_RTYPE1: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_SHIFT: uses_rt = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: uses_rs = 1'b1;
            OP_SW: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_beq  = 1'b1;
            end
            OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                is_bne  = 1'b1;
            end
            OP_J:    is_j  = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // Register 0 is hardwired, so a producer targeting it never matches.
    assign ex_hit_rs  = ex_v_q  & ex_wreg_q  & (ex_rn_q  != '0) & (ex_rn_q  == id_rs);
    assign ex_hit_rt  = ex_v_q  & ex_wreg_q  & (ex_rn_q  != '0) & (ex_rn_q  == id_rt);
    assign mem_hit_rs = mem_v_q & mem_wreg_q & (mem_rn_q != '0) & (mem_rn_q == id_rs);
    assign mem_hit_rt = mem_v_q & mem_wreg_q & (mem_rn_q != '0) & (mem_rn_q == id_rt);

    function automatic logic [1:0] fwd_sel(input logic used, input logic ex_hit,
                                           input logic ex_load, input logic mem_hit,
                                           input logic mem_load);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (ex_hit && !ex_load)
                sel = FWD_EX;
            else if (mem_hit)
                sel = mem_load ? FWD_LOAD : FWD_MEM;
        end
        return sel;
    endfunction

    always_comb begin
        id_valid = legal & ~id_kill_q;
        stall = id_valid &
                ((ex_m2reg_q & ((uses_rs & ex_hit_rs) | (uses_rt & ex_hit_rt))) |
                 ((is_beq | is_bne) & (ex_hit_rs | ex_hit_rt)));
        redirect = id_valid & ~stall &
                   ((is_beq & rsrtequ) | (is_bne & ~rsrtequ) | is_j);

        wpcir      = ~stall;
        ex_bubble  = stall;
        flush_ifid = redirect;
        pcsource   = PC_SEQ;
        if (redirect)
            pcsource = is_j ? PC_JUMP : PC_BRANCH;

        fwda = fwd_sel(id_valid & uses_rs, ex_hit_rs, ex_m2reg_q, mem_hit_rs, mem_m2reg_q);
        fwdb = fwd_sel(id_valid & uses_rt, ex_hit_rt, ex_m2reg_q, mem_hit_rt, mem_m2reg_q);
    end

    always_comb begin
        ex_v_d      = id_valid & ~stall;
        ex_wreg_d   = id_wreg;
        ex_m2reg_d  = id_m2reg;
        ex_rn_d     = id_rn;
        mem_v_d     = ex_v_q;
        mem_wreg_d  = ex_wreg_q;
        mem_m2reg_d = ex_m2reg_q;
        mem_rn_d    = ex_rn_q;
        id_kill_d   = redirect;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (redirect && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v_q      <= 1'b0;
            ex_wreg_q   <= 1'b0;
            ex_m2reg_q  <= 1'b0;
            ex_rn_q     <= '0;
            mem_v_q     <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_m2reg_q <= 1'b0;
            mem_rn_q    <= '0;
            id_kill_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_m2reg_q  <= ex_m2reg_d;
            ex_rn_q     <= ex_rn_d;
            mem_v_q     <= mem_v_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_rn_q    <= mem_rn_d;
            id_kill_q   <= id_kill_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; a narrow-counter second
// instance shares the stimulus so counter saturation is reached quickly.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_SH   = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000101;
    localparam logic [5:0] OP_ORI  = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b001101;
    localparam logic [5:0] OP_SW   = 6'b001110;
    localparam logic [5:0] OP_BEQ  = 6'b001111;
    localparam logic [5:0] OP_BNE  = 6'b010000;
    localparam logic [5:0] OP_J    = 6'b010010;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    typedef struct packed {
        logic       wpcir;
        logic       bub;
        logic       flush;
        logic [1:0] pcs;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [2:0] scs;
        logic [2:0] fcs;
    } exp_t;

    typedef struct packed {
        logic       wpcir;
        logic       bub;
        logic       flush;
        logic [1:0] pcs;
        logic [1:0] fa;
        logic [1:0] fb;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  id_op;
    logic [4:0]  id_rs, id_rt, id_rn;
    logic        id_wreg, id_m2reg, rsrtequ, clr_cnt;
    logic        wpcir, ex_bubble, flush_ifid;
    logic [1:0]  pcsource, fwda, fwdb;
    logic [15:0] stall_cnt, flush_cnt;
    logic        wpcir_s, ex_bubble_s, flush_ifid_s;
    logic [1:0]  pcsource_s, fwda_s, fwdb_s;
    logic [2:0]  stall_cnt_s, flush_cnt_s;

    int unsigned checks = 0;
    int unsigned failures = 0;

    exp_t  sb[$];
    string sb_tag[$];
    obs_t  ob;

    logic       m_ex_v, m_ex_w, m_ex_m, m_mem_v, m_mem_w, m_mem_m, m_kill;
    logic [4:0] m_ex_rn, m_mem_rn;
    int         m_sc, m_fc;
    logic       n_ex_v, n_ex_w, n_ex_m, n_mem_v, n_mem_w, n_mem_m, n_kill;
    logic [4:0] n_ex_rn, n_mem_rn;
    int         n_sc, n_fc;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .rsrtequ(rsrtequ), .clr_cnt(clr_cnt),
        .wpcir(wpcir), .ex_bubble(ex_bubble), .flush_ifid(flush_ifid), .pcsource(pcsource),
        .fwda(fwda), .fwdb(fwdb), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt), .id_rn(id_rn),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .rsrtequ(rsrtequ), .clr_cnt(clr_cnt),
        .wpcir(wpcir_s), .ex_bubble(ex_bubble_s), .flush_ifid(flush_ifid_s), .pcsource(pcsource_s),
        .fwda(fwda_s), .fwdb(fwdb_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // 0 illegal, 1 R-type, 2 shift, 3 imm ALU, 4 lw, 5 sw, 6 beq, 7 bne, 8 j
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001:                        return 1;
            6'b000010:                                   return 2;
            6'b000101, 6'b001001, 6'b001010, 6'b001100:  return 3;
            6'b001101:                                   return 4;
            6'b001110:                                   return 5;
            6'b001111:                                   return 6;
            6'b010000:                                   return 7;
            6'b010010:                                   return 8;
            default:                                     return 0;
        endcase
    endfunction

    function automatic bit hit(input logic v, input logic w, input logic [4:0] rn, input logic [4:0] r);
        return (v === 1'b1) && (w === 1'b1) && (rn != 5'd0) && (rn == r);
    endfunction

    function automatic logic [1:0] fwd_model(input bit used, input logic [4:0] r);
        if (!used) return 2'b00;
        if (hit(m_ex_v, m_ex_w, m_ex_rn, r) && !m_ex_m) return 2'b01;
        if (hit(m_mem_v, m_mem_w, m_mem_rn, r)) return m_mem_m ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex_v = 0; m_ex_w = 0; m_ex_m = 0; m_ex_rn = '0;
        m_mem_v = 0; m_mem_w = 0; m_mem_m = 0; m_mem_rn = '0;
        m_kill = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_advance();
        m_ex_v = n_ex_v; m_ex_w = n_ex_w; m_ex_m = n_ex_m; m_ex_rn = n_ex_rn;
        m_mem_v = n_mem_v; m_mem_w = n_mem_w; m_mem_m = n_mem_m; m_mem_rn = n_mem_rn;
        m_kill = n_kill; m_sc = n_sc; m_fc = n_fc;
    endtask

    task automatic model_eval(input string tag);
        int c;
        bit valid, urs, urt, ers, ert, stl, taken;
        exp_t e;
        c = op_class(id_op);
        valid = (c != 0) && !m_kill;
        urs = c inside {1, 3, 4, 5, 6, 7};
        urt = c inside {1, 2, 5, 6, 7};
        ers = hit(m_ex_v, m_ex_w, m_ex_rn, id_rs);
        ert = hit(m_ex_v, m_ex_w, m_ex_rn, id_rt);
        stl = valid && ((m_ex_m && ((urs && ers) || (urt && ert))) ||
                        ((c == 6 || c == 7) && (ers || ert)));
        taken = valid && !stl && ((c == 6 && rsrtequ) || (c == 7 && !rsrtequ) || c == 8);
        e.wpcir = !stl;
        e.bub   = stl;
        e.flush = taken;
        e.pcs   = !taken ? 2'b00 : ((c == 8) ? 2'b10 : 2'b01);
        e.fa    = fwd_model(valid && urs, id_rs);
        e.fb    = fwd_model(valid && urt, id_rt);
        e.sc    = 16'(m_sc);
        e.fc    = 16'(m_fc);
        e.scs   = (m_sc > 7) ? 3'd7 : 3'(m_sc);
        e.fcs   = (m_fc > 7) ? 3'd7 : 3'(m_fc);
        sb.push_back(e);
        sb_tag.push_back(tag);
        n_ex_v = valid && !stl; n_ex_w = id_wreg; n_ex_m = id_m2reg; n_ex_rn = id_rn;
        n_mem_v = m_ex_v; n_mem_w = m_ex_w; n_mem_m = m_ex_m; n_mem_rn = m_ex_rn;
        n_kill = taken;
        n_sc = clr_cnt ? 0 : ((stl && m_sc < 65535) ? m_sc + 1 : m_sc);
        n_fc = clr_cnt ? 0 : ((taken && m_fc < 65535) ? m_fc + 1 : m_fc);
    endtask

    task automatic check_out();
        exp_t e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty got=0 exp=1");
            return;
        end
        e = sb.pop_front();
        t = sb_tag.pop_front();
        cmp({t, ".wpcir"},      16'(wpcir),        16'(e.wpcir));
        cmp({t, ".ex_bubble"},  16'(ex_bubble),    16'(e.bub));
        cmp({t, ".flush_ifid"}, 16'(flush_ifid),   16'(e.flush));
        cmp({t, ".pcsource"},   16'(pcsource),     16'(e.pcs));
        cmp({t, ".fwda"},       16'(fwda),         16'(e.fa));
        cmp({t, ".fwdb"},       16'(fwdb),         16'(e.fb));
        cmp({t, ".stall_cnt"},  stall_cnt,         e.sc);
        cmp({t, ".flush_cnt"},  flush_cnt,         e.fc);
        cmp({t, ".s.wpcir"},    16'(wpcir_s),      16'(e.wpcir));
        cmp({t, ".s.pcsource"}, 16'(pcsource_s),   16'(e.pcs));
        cmp({t, ".s.flush"},    16'(flush_ifid_s), 16'(e.flush));
        cmp({t, ".s.bubble"},   16'(ex_bubble_s),  16'(e.bub));
        cmp({t, ".s.fwd"},      16'({fwda_s, fwdb_s}), 16'({e.fa, e.fb}));
        cmp({t, ".s.stall_cnt"}, 16'(stall_cnt_s), 16'(e.scs));
        cmp({t, ".s.flush_cnt"}, 16'(flush_cnt_s), 16'(e.fcs));
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rn, input logic w, input logic m,
                         input logic eq, input logic clr);
        id_op = op; id_rs = rs; id_rt = rt; id_rn = rn;
        id_wreg = w; id_m2reg = m; rsrtequ = eq; clr_cnt = clr;
    endtask

    // Starts and ends on a falling edge; one instruction occupies ID for one cycle.
    task automatic step(input string tag, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rn, input logic w,
                        input logic m, input logic eq, input logic clr, output obs_t o);
        drive(op, rs, rt, rn, w, m, eq, clr);
        model_eval(tag);
        #2;
        o.wpcir = wpcir; o.bub = ex_bubble; o.flush = flush_ifid;
        o.pcs = pcsource; o.fa = fwda; o.fb = fwdb;
        check_out();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        model_eval("reset");
        check_out();
        cmp("reset_wpcir", 16'(wpcir), 16'd1);
        cmp("reset_pcsource", 16'(pcsource), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // load-use: lw r3 ; add r4,r3,r5
        step("lw_r3",     OP_LW, 5'd1, 5'd3, 5'd3, 1, 1, 0, 0, ob);
        step("add_stall", OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
        cmp("lu_wpcir", 16'(ob.wpcir), 16'd0);
        cmp("lu_bubble", 16'(ob.bub), 16'd1);
        cmp("lu_stall_cnt", stall_cnt, 16'd1);
        step("add_go",    OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
        cmp("lu_fwda", 16'(ob.fa), 16'd3);
        cmp("lu_wpcir_after", 16'(ob.wpcir), 16'd1);

        // ALU forwarding from EX, then from MEM
        step("addi_r2",   OP_ADDI, 5'd1, 5'd2, 5'd2, 1, 0, 0, 0, ob);
        step("or_ex",     OP_R,    5'd1, 5'd2, 5'd6, 1, 0, 0, 0, ob);
        cmp("fwd_ex_fwdb", 16'(ob.fb), 16'd1);
        cmp("fwd_ex_wpcir", 16'(ob.wpcir), 16'd1);
        step("addi_r2b",  OP_ADDI, 5'd1, 5'd2, 5'd2, 1, 0, 0, 0, ob);
        step("ori_r9",    OP_ORI,  5'd1, 5'd9, 5'd9, 1, 0, 0, 0, ob);
        step("or_mem",    OP_R,    5'd1, 5'd2, 5'd6, 1, 0, 0, 0, ob);
        cmp("fwd_mem_fwdb", 16'(ob.fb), 16'd2);

        // branch on an EX producer: one stall, then taken with flush
        step("add_r7",    OP_R,   5'd1, 5'd1, 5'd7, 1, 0, 0, 0, ob);
        step("beq_stall", OP_BEQ, 5'd7, 5'd8, 5'd0, 0, 0, 1, 0, ob);
        cmp("beq_stall_wpcir", 16'(ob.wpcir), 16'd0);
        cmp("beq_stall_pcs", 16'(ob.pcs), 16'd0);
        step("beq_take",  OP_BEQ, 5'd7, 5'd8, 5'd0, 0, 0, 1, 0, ob);
        cmp("beq_pcs", 16'(ob.pcs), 16'd1);
        cmp("beq_flush", 16'(ob.flush), 16'd1);
        cmp("beq_flush_cnt", flush_cnt, 16'd1);
        step("killed_j",  OP_J,   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ob);
        cmp("killed_j_pcs", 16'(ob.pcs), 16'd0);
        cmp("killed_j_flush", 16'(ob.flush), 16'd0);

        // jump then killed bne
        step("j",         OP_J,   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ob);
        cmp("j_pcs", 16'(ob.pcs), 16'd2);
        cmp("j_flush", 16'(ob.flush), 16'd1);
        step("bne_killed", OP_BNE, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, ob);
        cmp("bne_killed_pcs", 16'(ob.pcs), 16'd0);

        // r0 never forwards; illegal opcode behaves as a bubble
        step("addi_r0",   OP_ADDI, 5'd1, 5'd0, 5'd0, 1, 0, 0, 0, ob);
        step("add_r0",    OP_R,    5'd0, 5'd0, 5'd10, 1, 0, 0, 0, ob);
        cmp("r0_fwd", 16'({ob.fa, ob.fb}), 16'd0);
        step("illegal",   OP_ILL,  5'd10, 5'd10, 5'd10, 1, 0, 0, 0, ob);
        cmp("illegal_fwda", 16'(ob.fa), 16'd0);
        cmp("illegal_wpcir", 16'(ob.wpcir), 16'd1);

        // shift ignores rs; sw picks up load data from MEM on rt
        step("lw_r12",    OP_LW, 5'd1, 5'd12, 5'd12, 1, 1, 0, 0, ob);
        step("shift",     OP_SH, 5'd12, 5'd1, 5'd13, 1, 0, 0, 0, ob);
        cmp("shift_wpcir", 16'(ob.wpcir), 16'd1);
        step("sw",        OP_SW, 5'd1, 5'd12, 5'd0, 0, 0, 0, 0, ob);
        cmp("sw_fwdb", 16'(ob.fb), 16'd3);

        for (int i = 0; i < 7; i++) begin
            step("sat_lw",  OP_LW, 5'd1, 5'd3, 5'd3, 1, 1, 0, 0, ob);
            step("sat_use", OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
            step("sat_go",  OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
        end
        cmp("sat_stall_cnt_s", 16'(stall_cnt_s), 16'd7);
        cmp("sat_stall_cnt", stall_cnt, 16'd9);
        for (int i = 0; i < 8; i++) begin
            step("sat_j",    OP_J, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ob);
            step("sat_kill", OP_J, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ob);
        end
        cmp("sat_flush_cnt_s", 16'(flush_cnt_s), 16'd7);
        cmp("sat_flush_cnt", flush_cnt, 16'd10);

        // asynchronous reset in the middle of a load-use stall
        step("rst_lw", OP_LW, 5'd1, 5'd3, 5'd3, 1, 1, 0, 0, ob);
        drive(OP_R, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        model_eval("rst_pre");
        #2;
        check_out();
        cmp("rst_pre_wpcir", 16'(wpcir), 16'd0);
        #1 rst = 1'b1;
        model_reset();
        #1;
        model_eval("rst_mid");
        check_out();
        cmp("rst_mid_wpcir", 16'(wpcir), 16'd1);
        cmp("rst_mid_bubble", 16'(ex_bubble), 16'd0);
        cmp("rst_mid_stall_cnt", stall_cnt, 16'd0);
        cmp("rst_mid_flush_cnt", flush_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst",  OP_R, 5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);

        // clear beats a simultaneous increment
        step("clr_j",     OP_J,  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, ob);
        step("clr_kill",  OP_R,  5'd1, 5'd1, 5'd0, 0, 0, 0, 0, ob);
        step("clr_lw",    OP_LW, 5'd1, 5'd3, 5'd3, 1, 1, 0, 0, ob);
        step("clr_use",   OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
        cmp("pre_clr_stall_cnt", stall_cnt, 16'd1);
        step("clr_go",    OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);
        step("clr_lw2",   OP_LW, 5'd1, 5'd3, 5'd3, 1, 1, 0, 0, ob);
        step("clr_stall", OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 1, ob);
        cmp("clr_stall_cnt", stall_cnt, 16'd0);
        cmp("clr_flush_cnt", flush_cnt, 16'd0);
        step("clr_after", OP_R,  5'd3, 5'd5, 5'd4, 1, 0, 0, 0, ob);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
